// File: rtl/btb_pkg.sv
// +------------------------------------------------------------------+
// | btb_pkg : shared geometry, counter encodings, BTB entry type      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package btb_pkg;

  localparam int BTB_DATA_WIDTH = 32;
  localparam int BTB_INDEX_BITS = 4;
  localparam int BTB_TAG_WIDTH  = BTB_DATA_WIDTH - BTB_INDEX_BITS - 2;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_STRONG_NT = 2'b00;
  localparam ctr_t CTR_WEAK_NT   = 2'b01;
  localparam ctr_t CTR_WEAK_T    = 2'b10;
  localparam ctr_t CTR_STRONG_T  = 2'b11;

  // Entry layout for the default geometry; the top re-declares it with its own widths.
  typedef struct packed {
    logic                      valid;
    logic [BTB_TAG_WIDTH-1:0]  tag;
    logic [BTB_DATA_WIDTH-1:0] target;
    ctr_t                      ctr;
  } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// +------------------------------------------------------------------+
// | sat_counter2 : 2-bit saturating up/down counter, next-state only  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter2
  import btb_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_ctr_d
);

  always_comb begin
    o_ctr_d = i_ctr;
    if (i_inc) begin
      if (i_ctr != CTR_STRONG_T) o_ctr_d = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_STRONG_NT) o_ctr_d = i_ctr - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor_btb.sv
// +------------------------------------------------------------------+
// | branch_predictor_btb : direct-mapped BTB with 2-bit counters,     |
// | EX-stage mispredict detection and statistics. Rev 1.0             |
// +------------------------------------------------------------------+
`default_nettype none

module branch_predictor_btb
  import btb_pkg::*;
#(
  parameter int DATA_WIDTH = BTB_DATA_WIDTH,
  parameter int INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_if_pc,
  output logic                  o_pred_taken,
  output logic [DATA_WIDTH-1:0] o_pred_pc,
  input  logic                  i_ex_valid,
  input  logic [DATA_WIDTH-1:0] i_ex_pc,
  input  logic [DATA_WIDTH-1:0] i_ex_target,
  input  logic [DATA_WIDTH-1:0] i_ex_pred_pc,
  input  logic                  i_ex_taken,
  input  logic                  i_ex_pred_taken,
  output logic                  o_mispredict,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  output logic [31:0]           o_branch_cnt,
  output logic [31:0]           o_mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] target;
    ctr_t                  ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  entry_t                if_entry;
  logic                  if_hit;

  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]      ex_tag;
  entry_t                ex_entry;
  logic                  ex_hit;
  ctr_t                  ex_ctr_d;
  entry_t                upd_entry_d;
  logic                  upd_we;

  logic [31:0]           branch_cnt_q, branch_cnt_d;
  logic [31:0]           mispred_cnt_q, mispred_cnt_d;

  // Fetch-side lookup reads the registered table, so a same-cycle update is not visible yet.
  assign if_idx   = i_if_pc[INDEX_BITS+1:2];
  assign if_tag   = i_if_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign if_entry = table_q[if_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);

  assign o_pred_taken = if_hit && if_entry.ctr[1];
  assign o_pred_pc    = o_pred_taken ? if_entry.target : i_if_pc + DATA_WIDTH'(4);

  assign o_mispredict  = i_ex_valid &&
                         ((i_ex_taken != i_ex_pred_taken) ||
                          (i_ex_taken && (i_ex_target != i_ex_pred_pc)));
  assign o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + DATA_WIDTH'(4);

  assign ex_idx   = i_ex_pc[INDEX_BITS+1:2];
  assign ex_tag   = i_ex_pc[DATA_WIDTH-1:INDEX_BITS+2];
  assign ex_entry = table_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  sat_counter2 u_sat_counter2 (
    .i_ctr   (ex_entry.ctr),
    .i_inc   (i_ex_taken),
    .o_ctr_d (ex_ctr_d)
  );

  always_comb begin
    upd_entry_d = ex_entry;
    upd_we      = 1'b0;
    if (i_ex_valid) begin
      if (ex_hit) begin
        upd_we          = 1'b1;
        upd_entry_d.ctr = ex_ctr_d;
        if (i_ex_taken) upd_entry_d.target = i_ex_target;
      end else if (i_ex_taken) begin
        upd_we             = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = ex_tag;
        upd_entry_d.target = i_ex_target;
        upd_entry_d.ctr    = CTR_WEAK_T;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].ctr    <= CTR_WEAK_NT;
      end
    end else if (upd_we) begin
      table_q[ex_idx] <= upd_entry_d;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_ex_valid && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (o_mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
// +------------------------------------------------------------------+
// | tb_branch_predictor_btb : directed + random checks against a     |
// | behavioural BTB model. Rev 1.0                                   |
// +------------------------------------------------------------------+
`default_nettype none

module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_pc = '0;
  logic        ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt, mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: plain arrays indexed by (pc/4) mod 16, tag = pc/64.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_bcnt, m_mcnt;

  always #5 clk = ~clk;

  branch_predictor_btb dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_if_pc         (if_pc),
    .o_pred_taken    (pred_taken),
    .o_pred_pc       (pred_pc),
    .i_ex_valid      (ex_valid),
    .i_ex_pc         (ex_pc),
    .i_ex_target     (ex_target),
    .i_ex_pred_pc    (ex_pred_pc),
    .i_ex_taken      (ex_taken),
    .i_ex_pred_taken (ex_pred_taken),
    .o_mispredict    (mispredict),
    .o_redirect_pc   (redirect_pc),
    .o_branch_cnt    (branch_cnt),
    .o_mispred_cnt   (mispred_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_bcnt = '0; m_mcnt = '0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int idx = int'((pc / 4) % 16);
    return m_valid[idx] && (m_tag[idx] == pc / 64);
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] ppc);
    int idx = int'((pc / 4) % 16);
    pt  = m_hit(pc) && (m_ctr[idx] >= 2);
    ppc = pt ? m_tgt[idx] : pc + 32'd4;
  endtask

  function automatic bit m_mis();
    return ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_pc));
  endfunction

  task automatic compare_model();
    bit          pt;
    logic [31:0] ppc;
    bit          mis;
    m_lookup(if_pc, pt, ppc);
    mis = m_mis();
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, pt});
    chk("pred_pc", pred_pc, ppc);
    chk("mispredict", {31'd0, mispredict}, {31'd0, mis});
    if (mis) chk("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispred_cnt", mispred_cnt, m_mcnt);
  endtask

  task automatic model_update();
    int idx = int'((ex_pc / 4) % 16);
    if (!ex_valid) return;
    if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
    if (m_mis() && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
    if (m_hit(ex_pc)) begin
      m_ctr[idx] = ex_taken ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                            : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
      if (ex_taken) m_tgt[idx] = ex_target;
    end else if (ex_taken) begin
      m_valid[idx] = 1; m_tag[idx] = ex_pc / 64; m_tgt[idx] = ex_target; m_ctr[idx] = 2;
    end
  endtask

  // One cycle: compare outputs mid-cycle, then advance the model with the DUT's edge.
  task automatic cyc();
    #2;
    compare_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ipc, input bit v, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [31:0] ppc,
                       input bit tk, input bit ptk);
    if_pc = ipc; ex_valid = v; ex_pc = pc; ex_target = tgt;
    ex_pred_pc = ppc; ex_taken = tk; ex_pred_taken = ptk;
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
    return 32'h100 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 3) << 2);
  endfunction

  initial begin
    bit          pt;
    logic [31:0] ppc;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_pc", pred_pc, 32'h104);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // First taken at 0x100 with empty table; same-cycle lookup must still miss.
    drive(32'h100, 1, 32'h100, 32'h200, 32'h104, 1, 0);
    chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    chk("alloc_redirect", redirect_pc, 32'h200);
    chk("same_cycle_pred", {31'd0, pred_taken}, 32'd0);
    cyc();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    chk("after_alloc_pred", {31'd0, pred_taken}, 32'd1);
    chk("after_alloc_pc", pred_pc, 32'h200);
    chk("branch_cnt_1", branch_cnt, 32'd1);
    chk("mispred_cnt_1", mispred_cnt, 32'd1);
    cyc();

    repeat (3) begin
      drive(32'h100, 1, 32'h100, 32'h200, 32'h200, 1, 1);
      cyc();
    end
    drive(32'h100, 1, 32'h100, 32'h200, 32'h200, 0, 1);
    chk("strong_t_pred", {31'd0, pred_taken}, 32'd1);
    cyc();
    drive(32'h100, 1, 32'h100, 32'h200, 32'h200, 0, 1);
    chk("weak_t_pred", {31'd0, pred_taken}, 32'd1);
    cyc();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    chk("weak_nt_pred", {31'd0, pred_taken}, 32'd0);
    chk("weak_nt_pc", pred_pc, 32'h104);
    cyc();

    repeat (2) begin
      drive(32'h100, 1, 32'h100, 32'h200, 32'h200, 1, 0);
      cyc();
    end
    drive(32'h140, 0, 0, 0, 0, 0, 0);
    chk("alias_pred", {31'd0, pred_taken}, 32'd0);
    chk("alias_pc", pred_pc, 32'h144);
    cyc();

    drive(32'h100, 1, 32'h100, 32'h300, 32'h200, 1, 1);
    chk("wrong_tgt_mis", {31'd0, mispredict}, 32'd1);
    chk("wrong_tgt_redirect", redirect_pc, 32'h300);
    cyc();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    chk("new_tgt_pc", pred_pc, 32'h300);
    cyc();

    // Asynchronous reset mid-run with a pending allocation that must be dropped.
    drive(32'h100, 1, 32'h500, 32'h600, 32'h504, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcnt", branch_cnt, 32'd0);
    chk("mid_rst_mcnt", mispred_cnt, 32'd0);
    chk("mid_rst_pred", {31'd0, pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    drive(32'h500, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
    chk("post_rst_pc", pred_pc, 32'h504);
    cyc();

    for (int n = 0; n < 600; n++) begin
      logic [31:0] epc;
      epc = rand_pc();
      if ($urandom_range(0, 1) == 1) m_lookup(epc, pt, ppc);
      else begin
        pt  = $urandom_range(0, 1) == 1;
        ppc = rand_pc();
      end
      drive(rand_pc(), $urandom_range(0, 2) != 0, epc,
            ($urandom_range(0, 1) == 1) ? 32'h200 : rand_pc(), ppc,
            $urandom_range(0, 1) == 1, pt);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
